// File: rtl/stopwatch_cnt_m.sv
// Four-digit BCD up/down stopwatch with prescaled tick, start/stop and lap freeze.
// state    | meaning
// STOPPED  | count held, live display
// RUNNING  | counting, live display
// LAP_RUN  | counting, display frozen on snapshot
// LAP_STOP | count held, display frozen on snapshot
module stopwatch_cnt_m #(
    parameter int TICK_DIV = 500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       lap_i,
    input  logic       clr_i,
    input  logic       up_i,
    output logic [3:0] dig0_o,
    output logic [3:0] dig1_o,
    output logic [3:0] dig2_o,
    output logic [3:0] dig3_o,
    output logic       running_o,
    output logic       lap_o,
    output logic       tick_o,
    output logic       rollover_o
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {STOPPED, RUNNING, LAP_RUN, LAP_STOP} state_t;

    state_t        state, state_nxt;
    logic          start_q, lap_q, armed;
    logic          start_edge, lap_edge;
    logic [PW-1:0] pre;
    logic [15:0]   count, snap, disp;
    logic          counting, tick_now;
    logic [16:0]   step;

    // Returns {wrap, next_value}; every digit stays in 0..9.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (up) begin
                    if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
                    else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
                    else begin
                        r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    // armed masks the first cycle after reset so a button held through reset is not an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q <= 1'b0;
            lap_q   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= start_i;
            lap_q   <= lap_i;
            armed   <= 1'b1;
        end
    end

    assign start_edge = armed & start_i & ~start_q;
    assign lap_edge   = armed & lap_i & ~lap_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= STOPPED;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr_i) begin
            state_nxt = STOPPED;
        end else if (start_edge) begin
            case (state)
                STOPPED:  state_nxt = RUNNING;
                RUNNING:  state_nxt = STOPPED;
                LAP_RUN:  state_nxt = LAP_STOP;
                LAP_STOP: state_nxt = LAP_RUN;
                default:  state_nxt = STOPPED;
            endcase
        end else if (lap_edge) begin
            case (state)
                RUNNING:  state_nxt = LAP_RUN;
                LAP_RUN:  state_nxt = RUNNING;
                LAP_STOP: state_nxt = STOPPED;
                default:  state_nxt = state;
            endcase
        end
    end

    assign counting = (state == RUNNING) || (state == LAP_RUN);
    assign tick_now = counting && (pre == PRE_MAX);
    assign step     = bcd_step(count, up_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre        <= '0;
            count      <= '0;
            snap       <= '0;
            tick_o     <= 1'b0;
            rollover_o <= 1'b0;
        end else if (clr_i) begin
            pre        <= '0;
            count      <= '0;
            snap       <= '0;
            tick_o     <= 1'b0;
            rollover_o <= 1'b0;
        end else begin
            tick_o     <= tick_now;
            rollover_o <= tick_now & step[16];
            if (counting) pre <= tick_now ? '0 : pre + PW'(1);
            if (tick_now) count <= step[15:0];
            if (state == RUNNING && state_nxt == LAP_RUN) snap <= count;
        end
    end

    assign running_o = counting;
    assign lap_o     = (state == LAP_RUN) || (state == LAP_STOP);
    assign disp      = lap_o ? snap : count;
    assign dig0_o    = disp[3:0];
    assign dig1_o    = disp[7:4];
    assign dig2_o    = disp[11:8];
    assign dig3_o    = disp[15:12];
endmodule

// File: tb/tb_stopwatch_cnt_m.sv
// Bench for stopwatch_cnt_m: directed test plan plus random buttons against an integer model.
module tb_stopwatch_cnt_m;
    localparam int TD = 4;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, lap_i, clr_i, up_i;
    logic [3:0] dig0_o, dig1_o, dig2_o, dig3_o;
    logic       running_o, lap_o, tick_o, rollover_o;

    int checks = 0;
    int errors = 0;

    // model: decimal count, run/lap flags instead of an encoded state
    int m_cnt, m_snap, m_pre;
    bit m_run, m_lap, m_tick, m_roll, m_sp, m_lp, m_armed;

    stopwatch_cnt_m #(.TICK_DIV(TD)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .lap_i(lap_i),
        .clr_i(clr_i), .up_i(up_i),
        .dig0_o(dig0_o), .dig1_o(dig1_o), .dig2_o(dig2_o), .dig3_o(dig3_o),
        .running_o(running_o), .lap_o(lap_o), .tick_o(tick_o), .rollover_o(rollover_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_snap = 0; m_pre = 0;
        m_run = 0; m_lap = 0; m_tick = 0; m_roll = 0;
        m_sp = 0; m_lp = 0; m_armed = 0;
    endtask

    task automatic model_step();
        bit se, le;
        int old;
        se = m_armed && start_i && !m_sp;
        le = m_armed && lap_i && !m_lp;
        m_sp = start_i; m_lp = lap_i; m_armed = 1;
        m_tick = 0; m_roll = 0;
        if (clr_i) begin
            m_run = 0; m_lap = 0; m_pre = 0; m_cnt = 0; m_snap = 0;
            return;
        end
        old = m_cnt;
        if (m_run) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                m_tick = 1;
                if (up_i) begin
                    m_roll = (m_cnt == 9999);
                    m_cnt = (m_cnt + 1) % 10000;
                end else begin
                    m_roll = (m_cnt == 0);
                    m_cnt = (m_cnt + 9999) % 10000;
                end
            end else begin
                m_pre++;
            end
        end
        if (se) m_run = !m_run;
        else if (le && (m_run || m_lap)) begin
            if (!m_lap) m_snap = old;
            m_lap = !m_lap;
        end
    endtask

    task automatic check_all();
        int disp;
        disp = m_lap ? m_snap : m_cnt;
        chk("dig0", 16'(dig0_o), 16'(disp % 10));
        chk("dig1", 16'(dig1_o), 16'((disp / 10) % 10));
        chk("dig2", 16'(dig2_o), 16'((disp / 100) % 10));
        chk("dig3", 16'(dig3_o), 16'((disp / 1000) % 10));
        chk("running", 16'(running_o), 16'(m_run));
        chk("lap", 16'(lap_o), 16'(m_lap));
        chk("tick", 16'(tick_o), 16'(m_tick));
        chk("rollover", 16'(rollover_o), 16'(m_roll));
    endtask

    task automatic cyc();
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
    endtask

    task automatic press_start();
        start_i = 1; cyc(); start_i = 0; cyc();
    endtask

    task automatic press_lap();
        lap_i = 1; cyc(); lap_i = 0; cyc();
    endtask

    task automatic do_clr();
        clr_i = 1; cyc(); clr_i = 0;
    endtask

    task automatic run_ticks(input int n, input string tag);
        int seen = 0;
        int budget = n * TD + 4 * TD;
        while (seen < n && budget > 0) begin
            cyc();
            if (m_tick) seen++;
            budget--;
        end
        if (seen < n) chk({tag, "_timeout"}, 16'(seen), 16'(n));
    endtask

    task automatic chk_disp(input string tag, input int v);
        chk({tag, "_d0"}, 16'(dig0_o), 16'(v % 10));
        chk({tag, "_d1"}, 16'(dig1_o), 16'((v / 10) % 10));
        chk({tag, "_d2"}, 16'(dig2_o), 16'((v / 100) % 10));
        chk({tag, "_d3"}, 16'(dig3_o), 16'((v / 1000) % 10));
    endtask

    initial begin
        int budget;
        int last_tick;
        rst_i = 1; start_i = 0; lap_i = 0; clr_i = 0; up_i = 1;
        model_reset();
        #2;
        check_all();
        #10 rst_i = 0;

        // up counting with carry at the 10th tick
        do_clr();
        up_i = 1;
        press_start();
        run_ticks(9, "up9");
        chk_disp("up9", 9);
        run_ticks(1, "up10");
        chk_disp("up10", 10);
        last_tick = $time;
        run_ticks(1, "up11");
        chk("tick_period", 16'(($time - last_tick) / 10), 16'(TD));
        run_ticks(29, "up40");
        chk_disp("up40", 40);

        // down wrap then up rollover
        do_clr();
        up_i = 0;
        press_start();
        run_ticks(1, "down1");
        chk_disp("down_wrap", 9999);
        chk("down_wrap_roll", 16'(rollover_o), 16'd1);
        run_ticks(1, "down2");
        chk_disp("down_next", 9998);
        chk("down_next_roll", 16'(rollover_o), 16'd0);
        up_i = 1;
        run_ticks(2, "uproll");
        chk_disp("up_roll", 0);
        chk("up_roll_flag", 16'(rollover_o), 16'd1);
        chk("up_roll_tick", 16'(tick_o), 16'd1);
        cyc();
        chk("up_roll_pulse", 16'(rollover_o), 16'd0);

        // lap sequence
        do_clr();
        press_start();
        budget = 200;
        while (m_cnt != 12 && budget > 0) begin cyc(); budget--; end
        chk("lap_reach12", 16'(m_cnt), 16'd12);
        press_lap();
        chk("lap_frozen", 16'(lap_o), 16'd1);
        run_ticks(5, "lap5");
        chk_disp("lap_hold", 12);
        press_lap();
        chk_disp("lap_release", 17);
        chk("lap_release_lap", 16'(lap_o), 16'd0);
        press_lap();
        press_start();
        chk("lapstop_run", 16'(running_o), 16'd0);
        chk("lapstop_lap", 16'(lap_o), 16'd1);
        press_lap();
        chk("stopped_run", 16'(running_o), 16'd0);
        chk("stopped_lap", 16'(lap_o), 16'd0);

        // start and lap edges together from RUNNING
        press_start();
        start_i = 1; lap_i = 1; cyc();
        start_i = 0; lap_i = 0; cyc();
        chk("both_run", 16'(running_o), 16'd0);
        chk("both_lap", 16'(lap_o), 16'd0);

        // clr together with a tick
        press_start();
        budget = 20;
        while (!(m_run && m_pre == TD - 1) && budget > 0) begin cyc(); budget--; end
        chk("clr_setup_pre", 16'(m_pre), 16'(TD - 1));
        do_clr();
        chk_disp("clr_tick", 0);
        chk("clr_tick_tick", 16'(tick_o), 16'd0);
        chk("clr_tick_run", 16'(running_o), 16'd0);

        // async reset mid-run with start held high through release
        press_start();
        run_ticks(3, "prerst");
        #2 rst_i = 1;
        #1;
        model_reset();
        check_all();
        start_i = 1;
        #2 rst_i = 0;
        repeat (5) cyc();
        chk("rst_no_edge", 16'(running_o), 16'd0);
        start_i = 0;
        cyc();

        // random buttons, clear and direction
        for (int i = 0; i < 3000; i++) begin
            start_i = ($urandom_range(0, 7) == 0);
            lap_i   = ($urandom_range(0, 5) == 0);
            clr_i   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) up_i = ~up_i;
            cyc();
        end
        start_i = 0; lap_i = 0; clr_i = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
